nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_pkg.sv | 16 +
 rtl/nibble_adder.sv | 23 ++
 rtl/nibble_serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/nibble_pkg.sv
// nibble_pkg: shared constants, FSM states and index sizing for the nibble-serial adder.
package nibble_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// nibble_adder: 4-bit ripple-carry adder built from four full-adder cells.
module nibble_adder
    import nibble_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/subtract sequenced one nibble per clock
// through a single shared 4-bit adder, with a start/busy/done handshake.
module nibble_serial_adder_ctrl
    import nibble_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_w(NIBBLES);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 carry_q, carry_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                 cout_q, cout_d, ovf_q, ovf_d;
    logic [NIBBLE_W-1:0]  slice_s;
    logic                 slice_co;

    nibble_adder u_adder (
        .x  (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .y  (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == RUN) begin
            sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;
            carry_d = slice_co;
            if (idx_q == IDX_W'(NIBBLES - 1)) begin
                state_d = DONE;
                cout_d  = slice_co;
                // Sign of the final slice is the sign of the full result.
                ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[NIBBLE_W-1] != a_q[WIDTH-1]);
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (start) begin
            state_d = RUN;
            idx_d   = '0;
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub | cin;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed and random add/sub checks against an arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int n_checks = 0;
    int n_errors = 0;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] ta, tb, input logic ts, tc);
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = ts ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, bb} + (W+1)'(ts ? 1'b1 : tc);
        return {(ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]), full[W], full[W-1:0]};
    endfunction

    task automatic run_op(input logic [W-1:0] ta, tb, input logic ts, tc, input bit poke);
        logic [W+1:0] e;
        e = model(ta, tb, ts, tc);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; sub = ts; cin = tc;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        chk("busy_accept", 32'(busy), 1);
        chk("done_accept", 32'(done), 0);
        for (int i = 1; i < NIB; i++) begin
            if (poke && i == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("busy_run", 32'(busy), 1);
            chk("done_run", 32'(done), 0);
        end
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 1);
        chk("busy_done", 32'(busy), 0);
        chk("sum", 32'(e[W-1:0]), 32'(sum));
        chk("cout", 32'(cout), 32'(e[W]));
        chk("ovf", 32'(ovf), 32'(e[W+1]));
        @(posedge clk); #1;
        chk("done_once", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("sum_held", 32'(sum), 32'(e[W-1:0]));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W+1:0] e1, e2;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_ovf", 32'(ovf), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
        run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset during the third RUN cycle.
        @(negedge clk);
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_sum", 32'(sum), 0);
        chk("arst_cout", 32'(cout), 0);
        chk("arst_ovf", 32'(ovf), 0);
        @(negedge clk); rst = 1'b0;
        run_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 1'b0);

        // Back-to-back: start held through DONE launches the next op with no bubble.
        e1 = model(16'h1111, 16'h2222, 1'b0, 1'b1);
        e2 = model(16'h4321, 16'h1234, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b1;
        @(posedge clk); #1;
        a = 16'h4321; b = 16'h1234; sub = 1'b1; cin = 1'b0;
        repeat (NIB) @(posedge clk);
        #1;
        chk("b2b_done1", 32'(done), 1);
        chk("b2b_sum1", 32'(sum), 32'(e1[W-1:0]));
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_done_off", 32'(done), 0);
        chk("b2b_sum_hold", 32'(sum), 32'(e1[W-1:0]));
        @(posedge clk); #1;
        chk("b2b_slice0", 32'(sum), 32'({e1[W-1:4], e2[3:0]}));
        repeat (NIB - 1) @(posedge clk);
        #1;
        chk("b2b_done2", 32'(done), 1);
        chk("b2b_sum2", 32'(sum), 32'(e2[W-1:0]));
        chk("b2b_cout2", 32'(cout), 32'(e2[W]));
        chk("b2b_ovf2", 32'(ovf), 32'(e2[W+1]));
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
